// File: rtl/pd_pwr_seq_gen.sv
// Power-domain control sequencer. Walks NUM_CTRL control lines one at a time
// toward an off or on target with a programmable spacing between steps.
// Supports per-step skip mask, mid-sequence reversal and a done pulse.
module pd_pwr_seq_gen #(
  parameter int                  NUM_CTRL = 5,
  parameter int                  DLY_W    = 4,
  parameter logic [NUM_CTRL-1:0] RST_VAL  = 5'b11001,
  localparam int                 IDX_W    = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1
) (
  input  logic                i_aon_clk,
  input  logic                i_soc_pwr_on_rst,
  input  logic                i_off_req,
  input  logic                i_on_req,
  input  logic [NUM_CTRL-1:0] i_off_tgt,
  input  logic [NUM_CTRL-1:0] i_on_tgt,
  input  logic [NUM_CTRL-1:0] i_step_en,
  input  logic [DLY_W-1:0]    i_off_delay,
  input  logic [DLY_W-1:0]    i_on_delay,
  output logic [NUM_CTRL-1:0] o_ctrl,
  output logic [1:0]          o_state,
  output logic                o_busy,
  output logic                o_done,
  output logic [IDX_W-1:0]    o_step_idx
);

  typedef enum logic [1:0] {
    IDLE_ON  = 2'b00,
    SEQ_OFF  = 2'b01,
    IDLE_OFF = 2'b10,
    SEQ_ON   = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CTRL-1:0] ctrl_q, ctrl_d;
  logic [NUM_CTRL-1:0] tgt_q, tgt_d;    // target of the running direction
  logic [NUM_CTRL-1:0] pend_q, pend_d;  // steps still to apply
  logic [NUM_CTRL-1:0] appl_q, appl_d;  // steps applied in this direction
  logic [DLY_W-1:0]    dly_q, dly_d;    // latched effective step spacing
  logic [DLY_W-1:0]    cnt_q, cnt_d;    // cycles left until next step
  logic                done_q, done_d;
  logic [IDX_W-1:0]    step_idx_q, step_idx_d;

  logic [DLY_W-1:0]    off_dly_eff;
  logic [DLY_W-1:0]    on_dly_eff;
  logic [IDX_W-1:0]    cur_idx;

  // Lowest set bit: the next step of an off sequence (ascending order).
  function automatic logic [IDX_W-1:0] lo_idx(input logic [NUM_CTRL-1:0] v);
    lo_idx = '0;
    for (int i = NUM_CTRL - 1; i >= 0; i--) begin
      if (v[i]) lo_idx = IDX_W'(i);
    end
  endfunction

  // Highest set bit: the next step of an on sequence (descending order).
  function automatic logic [IDX_W-1:0] hi_idx(input logic [NUM_CTRL-1:0] v);
    hi_idx = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (v[i]) hi_idx = IDX_W'(i);
    end
  endfunction

  // A programmed delay of zero still spaces steps by one cycle.
  assign off_dly_eff = (i_off_delay == '0) ? DLY_W'(1) : i_off_delay;
  assign on_dly_eff  = (i_on_delay == '0) ? DLY_W'(1) : i_on_delay;

  // Next-state logic: start, reversal, step application and completion.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    appl_d  = appl_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cur_idx = (state_q == SEQ_OFF) ? lo_idx(pend_q) : hi_idx(pend_q);

    unique case (state_q)
      IDLE_ON: begin
        if (i_off_req) begin
          state_d = SEQ_OFF;
          tgt_d   = i_off_tgt;
          pend_d  = i_step_en;
          appl_d  = '0;
          dly_d   = off_dly_eff;
          cnt_d   = off_dly_eff;
        end
      end
      IDLE_OFF: begin
        if (i_on_req) begin
          state_d = SEQ_ON;
          tgt_d   = i_on_tgt;
          pend_d  = i_step_en;
          appl_d  = '0;
          dly_d   = on_dly_eff;
          cnt_d   = on_dly_eff;
        end
      end
      SEQ_OFF, SEQ_ON: begin
        if (pend_q == '0) begin
          // Nothing to do (empty mask or reversal with no applied steps).
          state_d = (state_q == SEQ_OFF) ? IDLE_OFF : IDLE_ON;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if ((state_q == SEQ_OFF) && i_on_req) begin
          // Undo only what this direction already applied, newest first.
          state_d = SEQ_ON;
          tgt_d   = i_on_tgt;
          pend_d  = appl_q & i_step_en;
          appl_d  = '0;
          dly_d   = on_dly_eff;
          cnt_d   = on_dly_eff;
        end else if ((state_q == SEQ_ON) && i_off_req) begin
          state_d = SEQ_OFF;
          tgt_d   = i_off_tgt;
          pend_d  = appl_q & i_step_en;
          appl_d  = '0;
          dly_d   = off_dly_eff;
          cnt_d   = off_dly_eff;
        end else if (cnt_q == DLY_W'(1)) begin
          ctrl_d[cur_idx] = tgt_q[cur_idx];
          pend_d[cur_idx] = 1'b0;
          appl_d[cur_idx] = 1'b1;
          cnt_d           = dly_q;
          if (pend_d == '0) begin
            state_d = (state_q == SEQ_OFF) ? IDLE_OFF : IDLE_ON;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
    endcase

    if (state_d == SEQ_OFF) begin
      step_idx_d = lo_idx(pend_d);
    end else if (state_d == SEQ_ON) begin
      step_idx_d = hi_idx(pend_d);
    end else begin
      step_idx_d = '0;
    end
  end

  // State and output registers; reset overrides any request or sequence.
  always_ff @(posedge i_aon_clk) begin
    if (i_soc_pwr_on_rst) begin
      state_q    <= IDLE_ON;
      ctrl_q     <= RST_VAL;
      tgt_q      <= '0;
      pend_q     <= '0;
      appl_q     <= '0;
      dly_q      <= DLY_W'(1);
      cnt_q      <= '0;
      done_q     <= 1'b0;
      step_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      tgt_q      <= tgt_d;
      pend_q     <= pend_d;
      appl_q     <= appl_d;
      dly_q      <= dly_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      step_idx_q <= step_idx_d;
    end
  end

  assign o_ctrl     = ctrl_q;
  assign o_state    = state_q;
  assign o_busy     = (state_q == SEQ_OFF) || (state_q == SEQ_ON);
  assign o_done     = done_q;
  assign o_step_idx = step_idx_q;

endmodule

// File: tb/tb_pd_pwr_seq_gen.sv
// Testbench for pd_pwr_seq_gen: directed scenarios plus randomized runs
// checked cycle by cycle against a timeline model of the sequencer.
module tb_pd_pwr_seq_gen;

  logic       i_aon_clk;
  logic       i_soc_pwr_on_rst;
  logic       i_off_req;
  logic       i_on_req;
  logic [4:0] i_off_tgt;
  logic [4:0] i_on_tgt;
  logic [4:0] i_step_en;
  logic [3:0] i_off_delay;
  logic [3:0] i_on_delay;
  logic [4:0] o_ctrl;
  logic [1:0] o_state;
  logic       o_busy;
  logic       o_done;
  logic [2:0] o_step_idx;

  int n_cmp = 0;
  int n_err = 0;

  // Packed observation: {ctrl[4:0], state[1:0], done, busy, step_idx[2:0]}
  logic [11:0] obs_v [0:63];
  logic [11:0] exp_v [0:63];
  bit          model_fin_off;
  logic [4:0]  cur_ctrl;
  bit          cur_off;

  pd_pwr_seq_gen dut (
    .i_aon_clk        (i_aon_clk),
    .i_soc_pwr_on_rst (i_soc_pwr_on_rst),
    .i_off_req        (i_off_req),
    .i_on_req         (i_on_req),
    .i_off_tgt        (i_off_tgt),
    .i_on_tgt         (i_on_tgt),
    .i_step_en        (i_step_en),
    .i_off_delay      (i_off_delay),
    .i_on_delay       (i_on_delay),
    .o_ctrl           (o_ctrl),
    .o_state          (o_state),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_step_idx       (o_step_idx)
  );

  initial i_aon_clk = 1'b0;
  always #5 i_aon_clk = ~i_aon_clk;

  task automatic scramble();
    i_off_tgt   = 5'($urandom());
    i_on_tgt    = 5'($urandom());
    i_step_en   = 5'($urandom());
    i_off_delay = 4'($urandom());
    i_on_delay  = 4'($urandom());
  endtask

  task automatic set_cfg(input bit off_dir, input logic [4:0] t, input logic [4:0] m, input logic [3:0] d);
    i_step_en = m;
    if (off_dir) begin
      i_off_tgt = t; i_off_delay = d;
    end else begin
      i_on_tgt = t; i_on_delay = d;
    end
  endtask

  // Timeline model: step j of the start direction lands at edge (j+1)*D1.
  // A reversal at edge rev undoes the steps landed before rev, newest first,
  // landing at rev+(i+1)*D2. Edge 0 is the edge that samples the request.
  task automatic model_build(input logic [4:0] c0, input bit off_first, input logic [4:0] t1,
                             input logic [4:0] m1, input logic [3:0] d1raw, input int rev,
                             input logic [4:0] t2, input logic [3:0] d2raw, input int n);
    int s1[$];
    int u[$];
    int d1, d2, last, nxt, b;
    logic [4:0] c;
    logic [1:0] st;
    d1 = (d1raw == 4'd0) ? 1 : int'(d1raw);
    d2 = (d2raw == 4'd0) ? 1 : int'(d2raw);
    for (int k = 0; k < 5; k++) begin
      b = off_first ? k : 4 - k;
      if (m1[b]) s1.push_back(b);
    end
    if (rev < 0) begin
      last = (s1.size() == 0) ? 1 : s1.size() * d1;
      model_fin_off = off_first;
    end else begin
      for (int j = 0; j < s1.size(); j++)
        if ((j + 1) * d1 < rev) u.push_front(s1[j]);
      last = (u.size() == 0) ? rev + 1 : rev + u.size() * d2;
      model_fin_off = !off_first;
    end
    for (int e = 0; e < n; e++) begin
      c = c0;
      for (int j = 0; j < s1.size(); j++)
        if ((j + 1) * d1 <= e && (rev < 0 || (j + 1) * d1 < rev)) c[s1[j]] = t1[s1[j]];
      for (int i = 0; i < u.size(); i++)
        if (rev + (i + 1) * d2 <= e) c[u[i]] = t2[u[i]];
      if (e >= last)                   st = model_fin_off ? 2'b10 : 2'b00;
      else if (rev >= 0 && e >= rev)   st = off_first ? 2'b11 : 2'b01;
      else                             st = off_first ? 2'b01 : 2'b11;
      nxt = 0;
      if (e < last) begin
        if (rev < 0 || e < rev) begin
          for (int j = s1.size() - 1; j >= 0; j--)
            if ((j + 1) * d1 > e) nxt = s1[j];
        end else begin
          for (int i = u.size() - 1; i >= 0; i--)
            if (rev + (i + 1) * d2 > e) nxt = u[i];
        end
      end
      exp_v[e] = {c, st, (e == last), (e < last), 3'(nxt)};
    end
  endtask

  // Drives one request (and optional reversal at edge rev), scrambling all
  // inputs after they are latched; records one observation per edge.
  task automatic drive_run(input string name, input bit off_first, input logic [4:0] t1,
                           input logic [4:0] m1, input logic [3:0] d1, input int rev,
                           input logic [4:0] t2, input logic [3:0] d2, input int n);
    $display("run %s: start=%s tgt=%b mask=%b dly=%0d rev=%0d rtgt=%b rdly=%0d",
             name, off_first ? "off" : "on", t1, m1, d1, rev, t2, d2);
    scramble();
    set_cfg(off_first, t1, m1, d1);
    if (off_first) i_off_req = 1'b1; else i_on_req = 1'b1;
    for (int e = 0; e < n; e++) begin
      @(posedge i_aon_clk); #1;
      i_off_req = 1'b0;
      i_on_req  = 1'b0;
      scramble();
      if (e + 1 == rev) begin
        set_cfg(!off_first, t2, m1, d2);
        if (off_first) i_on_req = 1'b1; else i_off_req = 1'b1;
      end
      @(negedge i_aon_clk);
      obs_v[e] = {o_ctrl, o_state, o_done, o_busy, o_step_idx};
    end
  endtask

  task automatic test_reset();
    i_soc_pwr_on_rst = 1'b1;
    repeat (3) @(posedge i_aon_clk);
    @(negedge i_aon_clk);
    n_cmp++;
    if ({o_ctrl, o_state, o_done, o_busy, o_step_idx} !== {5'b11001, 2'b00, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_hold got %b required %b", {o_ctrl, o_state, o_done, o_busy, o_step_idx},
               {5'b11001, 2'b00, 5'b00000});
    end
    i_soc_pwr_on_rst = 1'b0;
    @(negedge i_aon_clk);
    n_cmp++;
    if ({o_ctrl, o_state, o_done, o_busy, o_step_idx} !== {5'b11001, 2'b00, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_release got %b required %b", {o_ctrl, o_state, o_done, o_busy, o_step_idx},
               {5'b11001, 2'b00, 5'b00000});
    end
    cur_ctrl = 5'b11001;
    cur_off  = 1'b0;
  endtask

  task automatic test_off_seq();
    model_build(cur_ctrl, 1'b1, 5'b00110, 5'b11111, 4'd2, -1, 5'b0, 4'd0, 12);
    drive_run("off_seq", 1'b1, 5'b00110, 5'b11111, 4'd2, -1, 5'b0, 4'd0, 12);
    for (int e = 0; e < 12; e++) begin
      n_cmp++;
      if (obs_v[e] !== exp_v[e]) begin
        n_err++;
        $display("FAIL off_seq e=%0d got %b required %b", e, obs_v[e], exp_v[e]);
      end
    end
    n_cmp++;
    if (obs_v[10] !== {5'b00110, 2'b10, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL off_seq_final got %b required %b", obs_v[10], {5'b00110, 2'b10, 5'b10000});
    end
    cur_ctrl = exp_v[11][11:7];
    cur_off  = model_fin_off;
  endtask

  task automatic test_on_seq();
    model_build(cur_ctrl, 1'b0, 5'b11001, 5'b11111, 4'd3, -1, 5'b0, 4'd0, 17);
    drive_run("on_seq", 1'b0, 5'b11001, 5'b11111, 4'd3, -1, 5'b0, 4'd0, 17);
    for (int e = 0; e < 17; e++) begin
      n_cmp++;
      if (obs_v[e] !== exp_v[e]) begin
        n_err++;
        $display("FAIL on_seq e=%0d got %b required %b", e, obs_v[e], exp_v[e]);
      end
    end
    n_cmp++;
    if (obs_v[16] !== {5'b11001, 2'b00, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL on_seq_final got %b required %b", obs_v[16], {5'b11001, 7'b0});
    end
    cur_ctrl = exp_v[16][11:7];
    cur_off  = model_fin_off;
  endtask

  task automatic test_mask_skip();
    model_build(cur_ctrl, 1'b1, 5'b00110, 5'b01001, 4'd1, -1, 5'b0, 4'd0, 4);
    drive_run("mask_skip", 1'b1, 5'b00110, 5'b01001, 4'd1, -1, 5'b0, 4'd0, 4);
    for (int e = 0; e < 4; e++) begin
      n_cmp++;
      if (obs_v[e] !== exp_v[e]) begin
        n_err++;
        $display("FAIL mask_skip e=%0d got %b required %b", e, obs_v[e], exp_v[e]);
      end
    end
    n_cmp++;
    if (obs_v[3][11:7] !== 5'b10000) begin
      n_err++;
      $display("FAIL mask_skip_final ctrl=%b required %b", obs_v[3][11:7], 5'b10000);
    end
    cur_ctrl = exp_v[3][11:7];
    cur_off  = model_fin_off;
  endtask

  task automatic test_reversal();
    model_build(cur_ctrl, 1'b0, 5'b11001, 5'b11111, 4'd1, -1, 5'b0, 4'd0, 7);
    drive_run("restore", 1'b0, 5'b11001, 5'b11111, 4'd1, -1, 5'b0, 4'd0, 7);
    for (int e = 0; e < 7; e++) begin
      n_cmp++;
      if (obs_v[e] !== exp_v[e]) begin
        n_err++;
        $display("FAIL restore e=%0d got %b required %b", e, obs_v[e], exp_v[e]);
      end
    end
    cur_ctrl = exp_v[6][11:7];
    model_build(cur_ctrl, 1'b1, 5'b00110, 5'b11111, 4'd2, 5, 5'b11001, 4'd2, 12);
    drive_run("reversal", 1'b1, 5'b00110, 5'b11111, 4'd2, 5, 5'b11001, 4'd2, 12);
    for (int e = 0; e < 12; e++) begin
      n_cmp++;
      if (obs_v[e] !== exp_v[e]) begin
        n_err++;
        $display("FAIL reversal e=%0d got %b required %b", e, obs_v[e], exp_v[e]);
      end
    end
    n_cmp++;
    if (obs_v[9] !== {5'b11001, 2'b00, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reversal_final got %b required %b", obs_v[9], {5'b11001, 2'b00, 5'b10000});
    end
    cur_ctrl = exp_v[11][11:7];
    cur_off  = model_fin_off;
  endtask

  task automatic test_delay0_reset();
    model_build(cur_ctrl, 1'b1, 5'b00110, 5'b11111, 4'd0, -1, 5'b0, 4'd0, 7);
    drive_run("delay0", 1'b1, 5'b00110, 5'b11111, 4'd0, -1, 5'b0, 4'd0, 7);
    for (int e = 0; e < 7; e++) begin
      n_cmp++;
      if (obs_v[e] !== exp_v[e]) begin
        n_err++;
        $display("FAIL delay0 e=%0d got %b required %b", e, obs_v[e], exp_v[e]);
      end
    end
    // On sequence from 00110, reset asserted for edge T+3.
    $display("run reset_mid: start=on tgt=11001 mask=11111 dly=2 reset_at=3");
    scramble();
    set_cfg(1'b0, 5'b11001, 5'b11111, 4'd2);
    i_on_req = 1'b1;
    @(posedge i_aon_clk); #1;
    i_on_req = 1'b0;
    @(posedge i_aon_clk); #1;
    @(posedge i_aon_clk); #1;
    i_soc_pwr_on_rst = 1'b1;
    @(negedge i_aon_clk);
    n_cmp++;
    if ({o_ctrl, o_state, o_done, o_busy, o_step_idx} !== {5'b10110, 2'b11, 1'b0, 1'b1, 3'd3}) begin
      n_err++;
      $display("FAIL reset_mid_pre got %b required %b", {o_ctrl, o_state, o_done, o_busy, o_step_idx},
               {5'b10110, 2'b11, 2'b01, 3'd3});
    end
    @(posedge i_aon_clk); #1;
    i_soc_pwr_on_rst = 1'b0;
    @(negedge i_aon_clk);
    n_cmp++;
    if ({o_ctrl, o_state, o_done, o_busy, o_step_idx} !== {5'b11001, 2'b00, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_mid got %b required %b", {o_ctrl, o_state, o_done, o_busy, o_step_idx},
               {5'b11001, 7'b0});
    end
    @(negedge i_aon_clk);
    n_cmp++;
    if ({o_ctrl, o_state, o_done, o_busy, o_step_idx} !== {5'b11001, 2'b00, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_mid_after got %b required %b", {o_ctrl, o_state, o_done, o_busy, o_step_idx},
               {5'b11001, 7'b0});
    end
    cur_ctrl = 5'b11001;
    cur_off  = 1'b0;
  endtask

  task automatic test_ignored_and_empty();
    logic [4:0] keep;
    $display("run ignore_on: on_req held in IDLE_ON");
    i_on_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_aon_clk);
      n_cmp++;
      if ({o_ctrl, o_state, o_done, o_busy, o_step_idx} !== {cur_ctrl, 2'b00, 5'b00000}) begin
        n_err++;
        $display("FAIL ignore_on k=%0d got %b required %b", k,
                 {o_ctrl, o_state, o_done, o_busy, o_step_idx}, {cur_ctrl, 7'b0});
      end
    end
    i_on_req = 1'b0;
    model_build(cur_ctrl, 1'b1, 5'b00110, 5'b11111, 4'd1, -1, 5'b0, 4'd0, 7);
    drive_run("to_off", 1'b1, 5'b00110, 5'b11111, 4'd1, -1, 5'b0, 4'd0, 7);
    for (int e = 0; e < 7; e++) begin
      n_cmp++;
      if (obs_v[e] !== exp_v[e]) begin
        n_err++;
        $display("FAIL to_off e=%0d got %b required %b", e, obs_v[e], exp_v[e]);
      end
    end
    cur_ctrl = exp_v[6][11:7];
    $display("run ignore_off: off_req held in IDLE_OFF");
    i_off_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_aon_clk);
      n_cmp++;
      if ({o_ctrl, o_state, o_done, o_busy, o_step_idx} !== {cur_ctrl, 2'b10, 5'b00000}) begin
        n_err++;
        $display("FAIL ignore_off k=%0d got %b required %b", k,
                 {o_ctrl, o_state, o_done, o_busy, o_step_idx}, {cur_ctrl, 2'b10, 5'b0});
      end
    end
    i_off_req = 1'b0;
    model_build(cur_ctrl, 1'b0, 5'b11001, 5'b00000, 4'd3, -1, 5'b0, 4'd0, 3);
    drive_run("on_mask0", 1'b0, 5'b11001, 5'b00000, 4'd3, -1, 5'b0, 4'd0, 3);
    for (int e = 0; e < 3; e++) begin
      n_cmp++;
      if (obs_v[e] !== exp_v[e]) begin
        n_err++;
        $display("FAIL on_mask0 e=%0d got %b required %b", e, obs_v[e], exp_v[e]);
      end
    end
    keep = cur_ctrl;
    model_build(cur_ctrl, 1'b1, 5'b11111, 5'b00000, 4'd5, -1, 5'b0, 4'd0, 3);
    drive_run("off_mask0", 1'b1, 5'b11111, 5'b00000, 4'd5, -1, 5'b0, 4'd0, 3);
    for (int e = 0; e < 3; e++) begin
      n_cmp++;
      if (obs_v[e] !== exp_v[e]) begin
        n_err++;
        $display("FAIL off_mask0 e=%0d got %b required %b", e, obs_v[e], exp_v[e]);
      end
    end
    n_cmp++;
    if (obs_v[1] !== {keep, 2'b10, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL off_mask0_done got %b required %b", obs_v[1], {keep, 2'b10, 5'b10000});
    end
    cur_ctrl = exp_v[2][11:7];
    cur_off  = model_fin_off;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [4:0] t1, m1, t2;
      logic [3:0] d1, d2;
      int rev, n1, j;
      bit off_first;
      off_first = !cur_off;
      t1  = 5'($urandom());
      m1  = 5'($urandom());
      t2  = 5'($urandom());
      d1  = 4'($urandom_range(3, 0));
      d2  = 4'($urandom_range(3, 0));
      rev = -1;
      n1  = $countones(m1);
      if (n1 > 0 && $urandom_range(2, 0) == 0) begin
        d1  = 4'($urandom_range(3, 2));
        j   = $urandom_range(n1 - 1, 0);
        rev = j * int'(d1) + int'($urandom_range(int'(d1) - 1, 1));
      end
      model_build(cur_ctrl, off_first, t1, m1, d1, rev, t2, d2, 36);
      drive_run("random", off_first, t1, m1, d1, rev, t2, d2, 36);
      for (int e = 0; e < 36; e++) begin
        n_cmp++;
        if (obs_v[e] !== exp_v[e]) begin
          n_err++;
          $display("FAIL random it=%0d e=%0d got %b required %b", it, e, obs_v[e], exp_v[e]);
        end
      end
      cur_ctrl = exp_v[35][11:7];
      cur_off  = model_fin_off;
    end
  endtask

  initial begin
    i_soc_pwr_on_rst = 1'b1;
    i_off_req        = 1'b0;
    i_on_req         = 1'b0;
    scramble();
    test_reset();
    test_off_seq();
    test_on_seq();
    test_mask_skip();
    test_reversal();
    test_delay0_reset();
    test_ignored_and_empty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
